i2s_chan_sched: RTL
===================

Name: i2s_chan_sched

Overview:
- Channel scheduler between per-channel sample sources/sinks and the shared 32-bit I2S TX/RX FIFOs.
- TX: interleaves left/right source streams into the TX FIFO as strict L,R word pairs according to the channel mode; zero-fills or duplicates missing slots.
- RX: de-interleaves RX FIFO L,R pairs into per-channel sink streams; discards unused slots.
- Sits between the stream/DMA front end and the FIFO push/pop ports that feed the I2S core.

Parameters:
- DATA_WIDTH, 32, sample word width (FIFO word width).
- CNT_WIDTH, 16, width of the frame counters.

Ports:
- clk_i  in  1  clock for all logic.
- rst_n_i  in  1  reset, synchronous, active-low.
- en_i  in  1  scheduler enable; 0 holds the FSMs in the L state and deasserts all handshakes.
- flush_i  in  1  synchronous restart: both FSMs return to L, hold register cleared.
- chm_i  in  2  channel mode: 00 stereo, 01 mono-left, 10 mono-right, 11 dup-left.
- txl_valid_i / txl_ready_o / txl_data_i  in/out/in  1/1/DATA_WIDTH  left TX source.
- txr_valid_i / txr_ready_o / txr_data_i  in/out/in  1/1/DATA_WIDTH  right TX source.
- txf_push_o / txf_ready_i / txf_data_o  out/in/out  1/1/DATA_WIDTH  TX FIFO push port; txf_ready_i = ~full.
- rxf_valid_i / rxf_pop_o / rxf_data_i  in/out/in  1/1/DATA_WIDTH  RX FIFO pop port; rxf_valid_i = ~empty.
- rxl_valid_o / rxl_ready_i / rxl_data_o  out/in/out  1/1/DATA_WIDTH  left RX sink.
- rxr_valid_o / rxr_ready_i / rxr_data_o  out/in/out  1/1/DATA_WIDTH  right RX sink.
- mode_o  out  2  channel mode currently latched.
- tx_frm_o  out  CNT_WIDTH  count of completed TX frames (R word pushed).
- rx_frm_o  out  CNT_WIDTH  count of completed RX frames (R word popped).

Behaviour:
- Reset (rst_n_i low at a clk_i edge):
  - TX and RX FSMs go to S_L; hold register = 0; mode register = 00; tx_frm_o = rx_frm_o = 0.
  - While rst_n_i = 0, all valid/ready/push/pop outputs = 0 combinationally. Data outputs = 0.
- Handshakes:
  - Valid/ready, zero latency, combinational pass-through.
  - A transfer occurs on a cycle where both sides are high.
  - No output handshake depends combinationally on its own partner's handshake in a loop.
- Mode latching:
  - chm_i is sampled into the mode register only when both FSMs are in S_L and en_i = 1.
  - Mode is constant for the duration of a frame.
  - A mid-frame change of chm_i takes effect at the next frame boundary.
- TX FSM, states S_L and S_R; each transition requires a push (txf_push_o & txf_ready_i):
  - stereo:
    - S_L: push txl_data; txl_ready_o = txf_ready_i; push = txl_valid_i.
    - S_R: the same with the right source.
  - mono-left: S_L as stereo; S_R pushes 0 unconditionally (push = 1); txr_ready_o = 0.
  - mono-right: S_L pushes 0 unconditionally; S_R as stereo.
  - dup-left:
    - S_L: consume left and capture it into the hold register.
    - S_R: push the hold register; txl_ready_o = 0 in S_R.
  - A TX source not used in the current state sees ready = 0.
  - tx_frm_o increments (modulo 2^CNT_WIDTH) on each S_R push.
- RX FSM, states S_L and S_R; each transition requires a pop (rxf_pop_o & rxf_valid_i):
  - A slot routed to a sink: rxX_valid_o = rxf_valid_i, rxf_pop_o = rxX_ready_i, rxX_data_o = rxf_data_i.
  - A discarded slot: rxf_pop_o = rxf_valid_i (pop immediately); sinks see valid = 0.
  - Routing per mode:
    - stereo: L to left, R to right.
    - mono-left: L to left, R discarded.
    - mono-right: L discarded, R to right.
    - dup-left: L to left, R discarded.
  - rx_frm_o increments on each S_R pop.
- en_i = 0:
  - All handshake outputs = 0; FSMs forced to S_L on the next edge.
  - Hold register and counters retained.
- flush_i = 1: same as en_i = 0, and the hold register is cleared; counters retained. flush_i has priority over en_i.
- Simultaneous events: TX and RX FSMs are fully independent; both may transfer in the same cycle.
- Counter wrap: 0xFFFF + 1 = 0x0000, no saturation.

Decomposition:
- Shared package i2s_pkg holds:
  - chm_e enum: CHM_STEREO, CHM_MONO_L, CHM_MONO_R, CHM_DUP_L.
  - slot_e enum: S_L, S_R.
- Natural sub-module: i2s_chan_deint, the RX de-interleave FSM plus routing.
- The TX side and the mode register stay in the top module.

Test Plan:
- Stereo TX: L stream 0x11,0x22 and R stream 0xA1,0xA2, txf_ready_i = 1 -> FIFO receives 0x11,0xA1,0x22,0xA2; tx_frm_o = 2.
- mono-right TX, R = 0x55 -> FIFO receives 0x0,0x55; txl_ready_o stays 0; dup-left with L = 0x77 -> FIFO receives 0x77,0x77.
- TX backpressure: txf_ready_i low for 5 cycles in S_R -> no push, no R consume, FSM stays in S_R; resumes with 0xA1 on release.
- RX stereo with rxr_ready_i = 0 -> L word 0xC0 goes to the left sink; R word 0xC1 is held until rxr_ready_i rises; mono-left pops the R slot without waiting on the sink.
- chm_i changes 00->11 while TX is in S_R -> current frame completes as stereo; mode_o = 11 only after the S_R push.
- flush_i mid-frame in S_R, and rst_n_i low mid-frame -> both FSMs in S_L the next cycle; reset also zeroes the counters and hold register, flush zeroes the hold register only.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types for the I2S channel scheduler.
//   chm_e  : channel mode (stereo, mono-left, mono-right, dup-left)
//   slot_e : frame slot of the TX and RX FSMs (left word, right word)
package i2s_pkg;

    typedef enum logic [1:0] {
        CHM_STEREO = 2'b00,
        CHM_MONO_L = 2'b01,
        CHM_MONO_R = 2'b10,
        CHM_DUP_L  = 2'b11
    } chm_e;

    typedef enum logic {
        S_L = 1'b0,
        S_R = 1'b1
    } slot_e;

endpackage

// File: rtl/i2s_chan_sched_if.sv
// Bundle of every non-clock/reset signal of the channel scheduler.
// Signal names are as seen from the scheduler (_i = into it, _o = out of it).
//   slave  : the scheduler itself
//   master : the surrounding logic (stream front end, FIFOs, control)
// Control : en_i, flush_i, chm_i; status: mode_o, tx_frm_o, rx_frm_o
// TX      : txl_*/txr_* sources, txf_* FIFO push port
// RX      : rxf_* FIFO pop port, rxl_*/rxr_* sinks
interface i2s_chan_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  en_i;
    logic                  flush_i;
    logic [1:0]            chm_i;

    logic                  txl_valid_i;
    logic                  txl_ready_o;
    logic [DATA_WIDTH-1:0] txl_data_i;
    logic                  txr_valid_i;
    logic                  txr_ready_o;
    logic [DATA_WIDTH-1:0] txr_data_i;
    logic                  txf_push_o;
    logic                  txf_ready_i;
    logic [DATA_WIDTH-1:0] txf_data_o;

    logic                  rxf_valid_i;
    logic                  rxf_pop_o;
    logic [DATA_WIDTH-1:0] rxf_data_i;
    logic                  rxl_valid_o;
    logic                  rxl_ready_i;
    logic [DATA_WIDTH-1:0] rxl_data_o;
    logic                  rxr_valid_o;
    logic                  rxr_ready_i;
    logic [DATA_WIDTH-1:0] rxr_data_o;

    logic [1:0]            mode_o;
    logic [CNT_WIDTH-1:0]  tx_frm_o;
    logic [CNT_WIDTH-1:0]  rx_frm_o;

    modport slave (
        input  en_i, flush_i, chm_i,
        input  txl_valid_i, txl_data_i, txr_valid_i, txr_data_i, txf_ready_i,
        output txl_ready_o, txr_ready_o, txf_push_o, txf_data_o,
        input  rxf_valid_i, rxf_data_i, rxl_ready_i, rxr_ready_i,
        output rxf_pop_o, rxl_valid_o, rxl_data_o, rxr_valid_o, rxr_data_o,
        output mode_o, tx_frm_o, rx_frm_o
    );

    modport master (
        output en_i, flush_i, chm_i,
        output txl_valid_i, txl_data_i, txr_valid_i, txr_data_i, txf_ready_i,
        input  txl_ready_o, txr_ready_o, txf_push_o, txf_data_o,
        output rxf_valid_i, rxf_data_i, rxl_ready_i, rxr_ready_i,
        input  rxf_pop_o, rxl_valid_o, rxl_data_o, rxr_valid_o, rxr_data_o,
        input  mode_o, tx_frm_o, rx_frm_o
    );
endinterface

// File: rtl/i2s_chan_deint.sv
// RX de-interleaver: walks RX FIFO words as L,R pairs and routes each slot
// to the left sink, the right sink, or discards it, according to the mode.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   active_i                1 = running; 0 = handshakes off, FSM back to S_L
//   mode_i                  channel mode in force for the current frame
//   state_o                 current slot (used by the top for mode latching)
//   rxf_valid_i/pop_o/data  RX FIFO pop port
//   rxl_*/rxr_*             left/right sink streams
//   frm_o                   completed RX frames (R word popped), wraps
module i2s_chan_deint
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  active_i,
    input  chm_e                  mode_i,
    output slot_e                 state_o,
    input  logic                  rxf_valid_i,
    output logic                  rxf_pop_o,
    input  logic [DATA_WIDTH-1:0] rxf_data_i,
    output logic                  rxl_valid_o,
    input  logic                  rxl_ready_i,
    output logic [DATA_WIDTH-1:0] rxl_data_o,
    output logic                  rxr_valid_o,
    input  logic                  rxr_ready_i,
    output logic [DATA_WIDTH-1:0] rxr_data_o,
    output logic [CNT_WIDTH-1:0]  frm_o
);

    slot_e                st_q;
    logic [CNT_WIDTH-1:0] frm_q;
    logic                 route_l;
    logic                 route_r;
    logic                 pop_fire;

    // Only the L slot of mono-right goes nowhere on the left side; only
    // stereo and mono-right keep the R slot.
    assign route_l = (st_q == S_L) && (mode_i != CHM_MONO_R);
    assign route_r = (st_q == S_R) &&
                     ((mode_i == CHM_STEREO) || (mode_i == CHM_MONO_R));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rxf_pop_o   = 1'b0;
        rxl_valid_o = 1'b0;
        rxr_valid_o = 1'b0;
        rxl_data_o  = '0;
        rxr_data_o  = '0;
        if (active_i) begin
            if (route_l) begin
                rxl_valid_o = rxf_valid_i;
                rxf_pop_o   = rxl_ready_i;
                rxl_data_o  = rxf_data_i;
            end else if (route_r) begin
                rxr_valid_o = rxf_valid_i;
                rxf_pop_o   = rxr_ready_i;
                rxr_data_o  = rxf_data_i;
            end else begin
                // Discarded slot: drain it without involving any sink.
                rxf_pop_o = rxf_valid_i;
            end
        end
    end

    assign pop_fire = rxf_pop_o & rxf_valid_i;

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            st_q  <= S_L;
            frm_q <= '0;
        end else begin
            if (!active_i) begin
                st_q <= S_L;
            end else if (pop_fire) begin
                st_q <= (st_q == S_L) ? S_R : S_L;
            end
            if (pop_fire && (st_q == S_R)) begin
                frm_q <= frm_q + CNT_WIDTH'(1);
            end
        end
    end

    assign state_o = st_q;
    assign frm_o   = frm_q;

endmodule

// File: rtl/i2s_chan_sched.sv
// I2S channel scheduler top. Interleaves left/right TX sources into the TX
// FIFO as L,R word pairs, and de-interleaves RX FIFO pairs to the sinks
// (via i2s_chan_deint). Owns the mode register and the TX slot FSM.
// Ports:
//   clk_i    clock
//   rst_n_i  synchronous active-low reset
//   bus      i2s_chan_sched_if.slave: control, TX/RX streams, FIFO ports,
//            latched mode and TX/RX frame counters
module i2s_chan_sched
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    i2s_chan_sched_if.slave    bus
);

    logic                  active;
    logic                  mode_sample;
    chm_e                  mode_q;
    chm_e                  mode_eff;
    slot_e                 tx_st_q;
    slot_e                 rx_st;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [CNT_WIDTH-1:0]  tx_frm_q;
    logic                  txl_ready;
    logic                  txr_ready;
    logic                  txf_push;
    logic [DATA_WIDTH-1:0] txf_data;
    logic                  tx_fire;

    // Reset, disable and flush all silence every handshake combinationally.
    assign active = rst_n_i & bus.en_i & ~bus.flush_i;

    // The mode may only change on a frame boundary of both directions. While
    // it is being sampled, chm_i is used directly so the L slot pushed in the
    // sampling cycle belongs to the same mode the register captures.
    assign mode_sample = active && (tx_st_q == S_L) && (rx_st == S_L);
    assign mode_eff    = mode_sample ? chm_e'(bus.chm_i) : mode_q;

    always_comb begin
        txl_ready = 1'b0;
        txr_ready = 1'b0;
        txf_push  = 1'b0;
        txf_data  = '0;
        if (active) begin
            if (tx_st_q == S_L) begin
                if (mode_eff == CHM_MONO_R) begin
                    txf_push = 1'b1;             // zero-filled left slot
                end else begin
                    txl_ready = bus.txf_ready_i;
                    txf_push  = bus.txl_valid_i;
                    txf_data  = bus.txl_data_i;
                end
            end else begin
                case (mode_eff)
                    CHM_STEREO, CHM_MONO_R: begin
                        txr_ready = bus.txf_ready_i;
                        txf_push  = bus.txr_valid_i;
                        txf_data  = bus.txr_data_i;
                    end
                    CHM_MONO_L: txf_push = 1'b1; // zero-filled right slot
                    CHM_DUP_L: begin
                        txf_push = 1'b1;
                        txf_data = hold_q;
                    end
                    default: txf_push = 1'b0;
                endcase
            end
        end
    end

    assign tx_fire = txf_push & bus.txf_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_st_q  <= S_L;
            mode_q   <= CHM_STEREO;
            // NOTE: the hold register is reset because dup-left exposes its
            // contents on the FIFO; leaving it X would leak into the stream.
            hold_q   <= '0;
            tx_frm_q <= '0;
        end else begin
            if (!active) begin
                tx_st_q <= S_L;
            end else if (tx_fire) begin
                tx_st_q <= (tx_st_q == S_L) ? S_R : S_L;
            end

            if (bus.flush_i) begin
                hold_q <= '0;
            end else if (tx_fire && (tx_st_q == S_L) && (mode_eff == CHM_DUP_L)) begin
                hold_q <= bus.txl_data_i;
            end

            if (tx_fire && (tx_st_q == S_R)) begin
                tx_frm_q <= tx_frm_q + CNT_WIDTH'(1);
            end

            if (mode_sample) begin
                mode_q <= chm_e'(bus.chm_i);
            end
        end
    end

    logic                  rxf_pop;
    logic                  rxl_valid;
    logic                  rxr_valid;
    logic [DATA_WIDTH-1:0] rxl_data;
    logic [DATA_WIDTH-1:0] rxr_data;
    logic [CNT_WIDTH-1:0]  rx_frm;

    i2s_chan_deint #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_deint (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .active_i    (active),
        .mode_i      (mode_eff),
        .state_o     (rx_st),
        .rxf_valid_i (bus.rxf_valid_i),
        .rxf_pop_o   (rxf_pop),
        .rxf_data_i  (bus.rxf_data_i),
        .rxl_valid_o (rxl_valid),
        .rxl_ready_i (bus.rxl_ready_i),
        .rxl_data_o  (rxl_data),
        .rxr_valid_o (rxr_valid),
        .rxr_ready_i (bus.rxr_ready_i),
        .rxr_data_o  (rxr_data),
        .frm_o       (rx_frm)
    );

    assign bus.txl_ready_o = txl_ready;
    assign bus.txr_ready_o = txr_ready;
    assign bus.txf_push_o  = txf_push;
    assign bus.txf_data_o  = txf_data;
    assign bus.rxf_pop_o   = rxf_pop;
    assign bus.rxl_valid_o = rxl_valid;
    assign bus.rxl_data_o  = rxl_data;
    assign bus.rxr_valid_o = rxr_valid;
    assign bus.rxr_data_o  = rxr_data;
    assign bus.mode_o      = mode_q;
    assign bus.tx_frm_o    = tx_frm_q;
    assign bus.rx_frm_o    = rx_frm;

endmodule
